// File: rtl/uart_recv.sv
// uart_recv: 8N1 UART receiver with a two-flop input synchronizer and mid-bit sampling.
// Build option UART_RECV_MAJORITY_EN: each bit is the 2-of-3 vote of samples spread around mid-bit.
module uart_recv #(
    parameter logic [13:0] BAUD_MAX = 14'd10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [13:0] SAMPLE_PT = (BAUD_MAX >> 1) - 14'd1;
    localparam logic [13:0] WRAP_PT   = BAUD_MAX - 14'd1;
`ifdef UART_RECV_MAJORITY_EN
    localparam logic [13:0] SPREAD    = BAUD_MAX >> 4;
    localparam logic [13:0] EARLY_PT  = SAMPLE_PT - SPREAD;
    localparam logic [13:0] DECIDE_PT = SAMPLE_PT + SPREAD;
`else
    localparam logic [13:0] DECIDE_PT = SAMPLE_PT;
`endif

    logic        r_sync1;
    logic        r_sync2;
    logic        r_din_prev;
    state_t      r_state;
    logic [13:0] r_baud_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift_reg;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_frame_err;

    logic        w_din_s;
    logic        w_fall;
    logic        w_wrap;
    logic        w_decide;
    logic        w_bit;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_din_prev <= 1'b1;
        end else begin
            r_sync1    <= din;
            r_sync2    <= r_sync1;
            r_din_prev <= r_sync2;
        end
    end

    assign w_din_s  = r_sync2;
    assign w_fall   = r_din_prev & ~w_din_s;
    assign w_wrap   = (r_baud_cnt == WRAP_PT);
    assign w_decide = (r_baud_cnt == DECIDE_PT);

`ifdef UART_RECV_MAJORITY_EN
    logic r_samp_early;
    logic r_samp_mid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_samp_early <= 1'b1;
            r_samp_mid   <= 1'b1;
        end else begin
            if (r_baud_cnt == EARLY_PT) begin
                r_samp_early <= w_din_s;
            end
            if (r_baud_cnt == SAMPLE_PT) begin
                r_samp_mid <= w_din_s;
            end
        end
    end

    // The late sample is taken live, so the vote resolves on the decision cycle itself.
    assign w_bit = (r_samp_early & r_samp_mid) |
                   (r_samp_early & w_din_s)    |
                   (r_samp_mid   & w_din_s);
`else
    assign w_bit = w_din_s;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_baud_cnt  <= 14'd0;
            r_bit_cnt   <= 3'd0;
            r_shift_reg <= 8'h00;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_baud_cnt <= 14'd0;
                    r_bit_cnt  <= 3'd0;
                    if (w_fall) begin
                        r_state <= START;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (w_decide && w_bit) begin
                        r_state    <= IDLE;
                        r_baud_cnt <= 14'd0;
                    end else if (w_wrap) begin
                        r_state    <= DATA;
                        r_baud_cnt <= 14'd0;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 14'd1;
                    end
                end
                DATA: begin
                    if (w_decide) begin
                        r_shift_reg[r_bit_cnt] <= w_bit;
                    end
                    if (w_wrap) begin
                        r_baud_cnt <= 14'd0;
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 14'd1;
                    end
                end
                STOP: begin
                    // Leave early so a start bit directly after the stop bit is not missed.
                    if (w_decide) begin
                        r_state    <= IDLE;
                        r_baud_cnt <= 14'd0;
                        if (w_bit) begin
                            r_data  <= r_shift_reg;
                            r_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 14'd1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_baud_cnt <= 14'd0;
                end
            endcase
        end
    end

    assign data      = r_data;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_recv.sv
// Testbench for uart_recv: directed and randomized 8N1 frames against a byte-level model.
// Uses a short bit period so every scenario fits in a few tens of thousands of cycles.
module tb_uart_recv;
    localparam int BAUD   = 160;
    localparam int HALF   = BAUD / 2;
    localparam int SPREAD = BAUD / 16;
`ifdef UART_RECV_MAJORITY_EN
    localparam int DECIDE_OFS = SPREAD;
`else
    localparam int DECIDE_OFS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_recv #(.BAUD_MAX(14'(BAUD))) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Monitor state, sampled 1 time unit after each rising edge.
    int         cyc            = 0;
    int         valid_cnt      = 0;
    int         ferr_cnt       = 0;
    int         both_cnt       = 0;
    int         busy_cyc       = 0;
    int         last_valid_cyc = 0;
    logic [7:0] got_q[$];

    // Byte-level model: last good byte the receiver should be holding.
    logic [7:0] model_data = 8'h00;
    int         start_cyc  = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (!rst) begin
                if (valid) begin
                    valid_cnt      = valid_cnt + 1;
                    last_valid_cyc = cyc;
                    got_q.push_back(data);
                end
                if (frame_err) ferr_cnt = ferr_cnt + 1;
                if (valid && frame_err) both_cnt = both_cnt + 1;
                if (busy) busy_cyc = busy_cyc + 1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time (cyc=%0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            din = v;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        din       = 1'b0;
        start_cyc = cyc;
        repeat (BAUD - 1) @(negedge clk);
        for (int j = 0; j < 8; j++) drive_bit(b[j], BAUD);
        drive_bit(stop, BAUD);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", data); end
        tests_run++;
        if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", valid); end
        tests_run++;
        if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
        drive_bit(1'b1, 8);
        $display("[TB] reset: data=%h valid=%b ferr=%b busy=%b", data, valid, frame_err, busy);
    endtask

    task automatic test_single_frame();
        int v0, f0, lat, lat_min;
        v0 = valid_cnt; f0 = ferr_cnt; got_q.delete();
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1, 4);
        model_data = 8'h55;
        lat     = last_valid_cyc - start_cyc;
        lat_min = 2 + 9 * BAUD + HALF + DECIDE_OFS;
        tests_run++;
        if (valid_cnt - v0 != 1) begin tests_failed++; $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0); end
        tests_run++;
        if (data !== model_data) begin tests_failed++; $display("FAIL single_data: got %h want %h", data, model_data); end
        tests_run++;
        if (ferr_cnt != f0) begin tests_failed++; $display("FAIL single_ferr: got %0d pulses want 0", ferr_cnt - f0); end
        tests_run++;
        if (lat < lat_min || lat > lat_min + 2) begin
            tests_failed++; $display("FAIL single_latency: got %0d want %0d..%0d", lat, lat_min, lat_min + 2);
        end
        $display("[TB] frame 55: data=%h latency=%0d", data, lat);
    endtask

    task automatic test_back_to_back();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt; got_q.delete();
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        drive_bit(1'b1, 4);
        model_data = 8'h3C;
        tests_run++;
        if (valid_cnt - v0 != 2) begin tests_failed++; $display("FAIL b2b_valid_count: got %0d want 2", valid_cnt - v0); end
        tests_run++;
        if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin
            tests_failed++; $display("FAIL b2b_first: got %h want a5", (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        tests_run++;
        if (got_q.size() < 2 || got_q[1] !== 8'h3C) begin
            tests_failed++; $display("FAIL b2b_second: got %h want 3c", (got_q.size() > 1) ? got_q[1] : 8'hxx);
        end
        tests_run++;
        if (ferr_cnt != f0) begin tests_failed++; $display("FAIL b2b_ferr: got %0d pulses want 0", ferr_cnt - f0); end
        $display("[TB] back-to-back: %0d bytes received, data=%h", got_q.size(), data);
    endtask

    task automatic test_start_glitch();
        int v0, f0, b0, bdur;
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cyc;
        drive_bit(1'b0, BAUD / 5);
        drive_bit(1'b1, BAUD * 2);
        bdur = busy_cyc - b0;
        tests_run++;
        if (valid_cnt != v0) begin tests_failed++; $display("FAIL glitch_valid: got %0d pulses want 0", valid_cnt - v0); end
        tests_run++;
        if (ferr_cnt != f0) begin tests_failed++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt - f0); end
        tests_run++;
        if (bdur < HALF + DECIDE_OFS - 1 || bdur > HALF + DECIDE_OFS + 2) begin
            tests_failed++; $display("FAIL glitch_busy_len: got %0d want about %0d", bdur, HALF + DECIDE_OFS);
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_idle: busy got %b want 0", busy); end
        $display("[TB] start glitch: busy for %0d cycles", bdur);
    endtask

    task automatic test_frame_error();
        int v0, f0;
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hF0, 1'b0);
        drive_bit(1'b1, 4);
        tests_run++;
        if (ferr_cnt - f0 != 1) begin tests_failed++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt - f0); end
        tests_run++;
        if (valid_cnt != v0) begin tests_failed++; $display("FAIL ferr_valid: got %0d pulses want 0", valid_cnt - v0); end
        tests_run++;
        if (data !== model_data) begin tests_failed++; $display("FAIL ferr_data_kept: got %h want %h", data, model_data); end
        $display("[TB] frame error F0: ferr pulses=%0d data=%h", ferr_cnt - f0, data);
    endtask

    task automatic test_reset_mid_frame();
        int v0, f0;
        @(negedge clk);
        din = 1'b0;
        repeat (BAUD - 1) @(negedge clk);
        for (int j = 0; j < 4; j++) drive_bit(j[0], BAUD);
        drive_bit(1'b1, BAUD / 4);
        rst = 1'b1;
        din = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++;
            if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL midrst_outputs: got data=%h valid=%b ferr=%b busy=%b want 00/0/0/0",
                         data, valid, frame_err, busy);
            end
        end
        rst = 1'b0;
        model_data = 8'h00;
        v0 = valid_cnt; f0 = ferr_cnt; got_q.delete();
        drive_bit(1'b1, BAUD * 2);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 4);
        model_data = 8'h81;
        tests_run++;
        if (valid_cnt - v0 != 1 || got_q.size() != 1) begin
            tests_failed++; $display("FAIL midrst_valid_count: got %0d want 1", valid_cnt - v0);
        end
        tests_run++;
        if (data !== 8'h81) begin tests_failed++; $display("FAIL midrst_data: got %h want 81", data); end
        tests_run++;
        if (ferr_cnt != f0) begin tests_failed++; $display("FAIL midrst_ferr: got %0d pulses want 0", ferr_cnt - f0); end
        $display("[TB] reset mid-frame then 81: data=%h", data);
    endtask

    task automatic test_majority();
        int v0;
        logic [7:0] expd;
`ifdef UART_RECV_MAJORITY_EN
        expd = 8'h00;
`else
        expd = 8'h04;
`endif
        v0 = valid_cnt;
        @(negedge clk);
        din = 1'b0;
        repeat (BAUD - 1) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
            for (int k = 0; k < BAUD; k++) begin
                @(negedge clk);
                din = (j == 2 && k >= 76 && k <= 84) ? 1'b1 : 1'b0;
            end
        end
        drive_bit(1'b1, BAUD);
        drive_bit(1'b1, 4);
        model_data = expd;
        tests_run++;
        if (valid_cnt - v0 != 1) begin tests_failed++; $display("FAIL glitch_bit_valid: got %0d want 1", valid_cnt - v0); end
        tests_run++;
        if (data !== expd) begin tests_failed++; $display("FAIL glitch_bit_data: got %h want %h", data, expd); end
        $display("[TB] mid-bit glitch on 00: data=%h", data);
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int         exp_ferr, f0, gap;
        logic [7:0] b;
        logic       good;
        got_q.delete();
        f0 = ferr_cnt;
        exp_ferr = 0;
        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 3) != 0);
            gap  = $urandom_range(0, BAUD);
            send_frame(b, good);
            if (good) begin
                exp_q.push_back(b);
                model_data = b;
            end else begin
                exp_ferr++;
                gap = gap + 4;
            end
            if (gap > 0) drive_bit(1'b1, gap);
            $display("[TB] random frame %0d: byte=%h stop=%b gap=%0d", n, b, good, gap);
        end
        drive_bit(1'b1, 4);
        tests_run++;
        if (got_q.size() != exp_q.size()) begin
            tests_failed++; $display("FAIL rand_count: got %0d bytes want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin
                tests_failed++; $display("FAIL rand_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
        tests_run++;
        if (ferr_cnt - f0 != exp_ferr) begin
            tests_failed++; $display("FAIL rand_ferr: got %0d want %0d", ferr_cnt - f0, exp_ferr);
        end
        tests_run++;
        if (data !== model_data) begin tests_failed++; $display("FAIL rand_data: got %h want %h", data, model_data); end
        tests_run++;
        if (both_cnt != 0) begin tests_failed++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_reset_mid_frame();
        test_majority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
